// File: rtl/usb_send_packet.sv
// usb_send_packet: transmit packet framer between the host transaction controller and the SIE.
// Builds PID, token (CRC5), data (CRC16) and handshake packets as a byte stream.
// Optional feature: define USB_SOF_TOKEN_EN to frame SOF tokens (PID 5) from frameNum.
module usb_send_packet #(
  parameter int unsigned MAX_DATA_BYTES = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  sendPacketPID,
  input  logic        sendPacketWEn,
  output logic        sendPacketRdy,
  input  logic [6:0]  tokenAddr,
  input  logic [3:0]  tokenEndp,
  input  logic [10:0] frameNum,
  input  logic [7:0]  fifoData,
  input  logic        fifoEmpty,
  output logic        fifoREn,
  output logic [7:0]  sieData,
  output logic        sieValid,
  input  logic        sieReady,
  output logic        sieLast
);

  typedef enum logic [2:0] {
    StIdle, StPid, StTok1, StTok2, StData, StCrcLo, StCrcHi, StDone
  } state_t;

  typedef enum logic [1:0] {ClsBad, ClsTok, ClsData, ClsHs} pid_cls_t;

  localparam logic [9:0] MaxCount = 10'(MAX_DATA_BYTES);

  function automatic pid_cls_t pid_class(input logic [3:0] pid);
    pid_cls_t cls;
    case (pid)
      4'h1, 4'h9, 4'hd: cls = ClsTok;
`ifdef USB_SOF_TOKEN_EN
      4'h5:             cls = ClsTok;
`endif
      4'h3, 4'hb:       cls = ClsData;
      4'h2, 4'ha, 4'he: cls = ClsHs;
      default:          cls = ClsBad;
    endcase
    return cls;
  endfunction

  // Result is complemented and bit-reversed so it drops straight into byte[7:3] (c4 first on wire)
  function automatic logic [4:0] crc5_bits(input logic [10:0] f);
    logic [4:0] c;
    logic       fb;
    c = 5'b11111;
    for (int i = 0; i < 11; i++) begin
      fb = f[i] ^ c[4];
      c  = {c[3:0], 1'b0} ^ (fb ? 5'b00101 : 5'b00000);
    end
    return ~{c[0], c[1], c[2], c[3], c[4]};
  endfunction

  function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in, input logic [7:0] d);
    logic [15:0] c;
    c = crc_in ^ {8'h00, d};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return c;
  endfunction

  state_t      r_state;
  logic [3:0]  r_pid;
  logic [10:0] r_field;
  logic [15:0] r_crc16;
  logic [9:0]  r_count;
  logic        r_rdy;
  logic [7:0]  r_sie_data;
  logic        r_sie_valid;
  logic        r_sie_last;

  pid_cls_t    w_new_cls;
  pid_cls_t    w_cur_cls;
  logic [4:0]  w_crc5;
  logic        w_byte_acc;
  logic        w_data_avail;
  logic        w_data_xfer;

  assign w_new_cls    = pid_class(sendPacketPID);
  assign w_cur_cls    = pid_class(r_pid);
  assign w_crc5       = crc5_bits(r_field);
  assign w_byte_acc   = r_sie_valid & sieReady;
  // Payload bytes pass straight from the FWFT head so the next byte is ready right after a pop
  assign w_data_avail = (r_state == StData) & ~fifoEmpty & (r_count != MaxCount);
  assign w_data_xfer  = w_data_avail & sieReady;

  assign fifoREn       = w_data_xfer & ~rst;
  assign sendPacketRdy = r_rdy;
  assign sieValid      = (r_state == StData) ? w_data_avail : r_sie_valid;
  assign sieData       = (r_state == StData) ? fifoData : r_sie_data;
  assign sieLast       = r_sie_last;

  // Framer FSM: sequences packet bytes and holds each registered byte until the SIE takes it
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_pid       <= 4'h0;
      r_field     <= 11'h000;
      r_crc16     <= 16'hFFFF;
      r_count     <= 10'd0;
      r_rdy       <= 1'b0;
      r_sie_data  <= 8'h00;
      r_sie_valid <= 1'b0;
      r_sie_last  <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          r_rdy <= 1'b1;
          if (r_rdy && sendPacketWEn) begin
            r_rdy   <= 1'b0;
            r_pid   <= sendPacketPID;
            // frameNum only matters for SOF; for other PIDs the token field is {endp, addr}
            r_field <= (sendPacketPID == 4'h5) ? frameNum : {tokenEndp, tokenAddr};
            if (w_new_cls == ClsBad) begin
              r_state <= StDone;
            end else begin
              r_state     <= StPid;
              r_sie_data  <= {~sendPacketPID, sendPacketPID};
              r_sie_valid <= 1'b1;
              r_sie_last  <= (w_new_cls == ClsHs);
            end
          end
        end
        StPid: begin
          if (w_byte_acc) begin
            case (w_cur_cls)
              ClsTok: begin
                r_state    <= StTok1;
                r_sie_data <= r_field[7:0];
              end
              ClsData: begin
                r_state     <= StData;
                r_sie_valid <= 1'b0;
                r_crc16     <= 16'hFFFF;
                r_count     <= 10'd0;
              end
              default: begin
                r_state     <= StDone;
                r_sie_valid <= 1'b0;
                r_sie_last  <= 1'b0;
              end
            endcase
          end
        end
        StTok1: begin
          if (w_byte_acc) begin
            r_state    <= StTok2;
            r_sie_data <= {w_crc5, r_field[10:8]};
            r_sie_last <= 1'b1;
          end
        end
        StTok2: begin
          if (w_byte_acc) begin
            r_state     <= StDone;
            r_sie_valid <= 1'b0;
            r_sie_last  <= 1'b0;
          end
        end
        StData: begin
          if (w_data_xfer) begin
            r_crc16 <= crc16_byte(r_crc16, fifoData);
            r_count <= r_count + 10'd1;
          end else if (!w_data_avail) begin
            // FIFO drained or byte cap reached: close the payload, never wait for more data
            r_state     <= StCrcLo;
            r_sie_data  <= ~r_crc16[7:0];
            r_sie_valid <= 1'b1;
          end
        end
        StCrcLo: begin
          if (w_byte_acc) begin
            r_state    <= StCrcHi;
            r_sie_data <= ~r_crc16[15:8];
            r_sie_last <= 1'b1;
          end
        end
        StCrcHi: begin
          if (w_byte_acc) begin
            r_state     <= StDone;
            r_sie_valid <= 1'b0;
            r_sie_last  <= 1'b0;
          end
        end
        StDone: begin
          r_state <= StIdle;
          r_rdy   <= 1'b1;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usb_send_packet.sv
// Bench for usb_send_packet: spec vector table, randomized packets against a wire-level model,
// and hand-written reset/ignore sequences.
`timescale 1ns/1ps
module tb_usb_send_packet;

  localparam int TbMax = 12;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  sendPacketPID = 4'h0;
  logic        sendPacketWEn = 1'b0;
  logic        sendPacketRdy;
  logic [6:0]  tokenAddr = 7'h00;
  logic [3:0]  tokenEndp = 4'h0;
  logic [10:0] frameNum = 11'h000;
  logic [7:0]  fifoData = 8'h00;
  logic        fifoEmpty = 1'b1;
  logic        fifoREn;
  logic [7:0]  sieData;
  logic        sieValid;
  logic        sieReady = 1'b1;
  logic        sieLast;

  always #5 clk = ~clk;

  usb_send_packet #(.MAX_DATA_BYTES(TbMax)) dut (
    .clk(clk), .rst(rst),
    .sendPacketPID(sendPacketPID), .sendPacketWEn(sendPacketWEn), .sendPacketRdy(sendPacketRdy),
    .tokenAddr(tokenAddr), .tokenEndp(tokenEndp), .frameNum(frameNum),
    .fifoData(fifoData), .fifoEmpty(fifoEmpty), .fifoREn(fifoREn),
    .sieData(sieData), .sieValid(sieValid), .sieReady(sieReady), .sieLast(sieLast)
  );

  typedef struct {
    logic [3:0]      pid;
    logic [6:0]      addr;
    logic [3:0]      endp;
    int              npay;
    int              rmode;
    int              stall_at;
    int              exp_len;
    int              npre;
    logic [2:0][7:0] pre;
  } vec_t;

  vec_t       vecs[12];
  int         n_tests = 0;
  int         n_fail = 0;
  logic [7:0] pay_q[$];
  logic [7:0] fifo_q[$];
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, req, req);
    end
  endtask

  // 0 undefined, 1 token, 2 data, 3 handshake
  function automatic int pid_kind(input logic [3:0] pid);
    case (pid)
      4'h1, 4'h9, 4'hd: return 1;
`ifdef USB_SOF_TOKEN_EN
      4'h5: return 1;
`endif
      4'h3, 4'hb: return 2;
      4'h2, 4'ha, 4'he: return 3;
      default: return 0;
    endcase
  endfunction

  // Reference: build the serial wire bit stream (LSB-first) with plain MSB-first LFSRs,
  // then pack it back into bytes.
  task automatic build_expected(input logic [3:0] pid, input logic [6:0] addr,
                                input logic [3:0] endp, input logic [10:0] frame);
    logic        wire_bits[$];
    logic [10:0] f;
    logic [4:0]  c5;
    logic [15:0] c16;
    logic        fb;
    logic [7:0]  b;
    int          k;
    exp_q.delete();
    k = pid_kind(pid);
    if (k == 0) return;
    exp_q.push_back({~pid, pid});
    if (k == 3) return;
    if (k == 1) begin
      f  = (pid == 4'h5) ? frame : {endp, addr};
      c5 = 5'h1f;
      for (int i = 0; i < 11; i++) begin
        wire_bits.push_back(f[i]);
        fb = f[i] ^ c5[4];
        c5 = {c5[3:0], 1'b0} ^ {2'b00, fb, 1'b0, fb};
      end
      for (int i = 4; i >= 0; i--) wire_bits.push_back(~c5[i]);
    end else begin
      c16 = 16'hffff;
      for (int j = 0; j < pay_q.size() && j < TbMax; j++) begin
        b = pay_q[j];
        for (int i = 0; i < 8; i++) begin
          wire_bits.push_back(b[i]);
          fb  = b[i] ^ c16[15];
          c16 = {c16[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
        end
      end
      for (int i = 15; i >= 0; i--) wire_bits.push_back(~c16[i]);
    end
    for (int j = 0; j + 7 < wire_bits.size(); j += 8) begin
      for (int i = 0; i < 8; i++) b[i] = wire_bits[j + i];
      exp_q.push_back(b);
    end
  endtask

  task automatic drive_fifo();
    fifoEmpty = (fifo_q.size() == 0);
    fifoData  = (fifo_q.size() == 0) ? 8'h00 : fifo_q[0];
  endtask

  task automatic wait_rdy();
    int n;
    n = 0;
    @(negedge clk);
    while (!sendPacketRdy && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("rdy_before_packet", int'(sendPacketRdy), 1);
  endtask

  // Sends one packet; payload comes from pay_q. rmode 0: ready high, 1: random, 2: 3-cycle stall.
  task automatic run_packet(input logic [3:0] pid, input logic [6:0] addr,
                            input logic [3:0] endp, input logic [10:0] frame,
                            input int rmode, input int stall_at);
    int   cyc, rdy_cyc, last_acc, last_idx, last_cnt, pops, holdv, popbad, stall_left, exp_pops;
    logic pv, pacc, pl, popped, stalled;
    logic [7:0] pd;
    build_expected(pid, addr, endp, frame);
    exp_pops = (pid_kind(pid) == 2) ? ((pay_q.size() < TbMax) ? pay_q.size() : TbMax) : 0;
    wait_rdy();
    fifo_q = pay_q;
    drive_fifo();
    sendPacketPID = pid;
    tokenAddr     = addr;
    tokenEndp     = endp;
    frameNum      = frame;
    sendPacketWEn = 1'b1;
    sieReady      = 1'b1;
    got_q.delete();
    cyc = 0; rdy_cyc = -1; last_acc = -1; last_idx = -1; last_cnt = 0;
    pops = 0; holdv = 0; popbad = 0; stall_left = 0; stalled = 1'b0;
    pv = 1'b0; pacc = 1'b0; pl = 1'b0; pd = 8'h00; popped = 1'b0;
    while (rdy_cyc < 0 && cyc < 400) begin
      @(posedge clk);
      #1;
      sendPacketWEn = 1'b0;
      if (popped && fifo_q.size() > 0) void'(fifo_q.pop_front());
      drive_fifo();
      if (stall_left > 0) begin
        sieReady = 1'b0;
        stall_left--;
      end else if (rmode == 2 && !stalled && got_q.size() == stall_at) begin
        sieReady   = 1'b0;
        stall_left = 2;
        stalled    = 1'b1;
      end else if (rmode == 1) begin
        sieReady = ($urandom_range(0, 3) != 0);
      end else begin
        sieReady = 1'b1;
      end
      cyc++;
      @(negedge clk);
      if (cyc == 1) begin
        check("first_valid_latency", int'(sieValid), int'(exp_q.size() != 0));
        check("rdy_drop_after_accept", int'(sendPacketRdy), 0);
      end
      if (pv && !pacc && (!sieValid || sieData != pd || sieLast != pl)) holdv++;
      if (fifoREn) begin
        pops++;
        if (fifoEmpty) popbad++;
      end
      popped = fifoREn;
      pacc   = sieValid && sieReady;
      if (pacc) begin
        got_q.push_back(sieData);
        if (sieLast) begin
          last_cnt++;
          last_idx = got_q.size() - 1;
          last_acc = cyc;
        end
      end
      pv = sieValid; pd = sieData; pl = sieLast;
      if (sendPacketRdy) rdy_cyc = cyc;
    end
    if (rdy_cyc < 0) check("timeout_rdy_return", 0, 1);
    check("byte_count", got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      check($sformatf("byte%0d_pid%0h", i, pid), int'(got_q[i]), int'(exp_q[i]));
    end
    check("last_flag_count", last_cnt, (exp_q.size() != 0) ? 1 : 0);
    if (exp_q.size() != 0) check("last_on_final_byte", last_idx, exp_q.size() - 1);
    check("fifo_pops", pops, exp_pops);
    check("fifo_pop_while_empty", popbad, 0);
    check("hold_stable", holdv, 0);
    check("rdy_return_cycle", rdy_cyc, (exp_q.size() != 0) ? last_acc + 2 : 2);
  endtask

  task automatic set_vec(input int idx, input logic [3:0] pid, input logic [6:0] addr,
                         input logic [3:0] endp, input int npay, input int rmode,
                         input int stall_at, input int exp_len, input int npre,
                         input logic [7:0] p0, input logic [7:0] p1, input logic [7:0] p2);
    vecs[idx].pid      = pid;
    vecs[idx].addr     = addr;
    vecs[idx].endp     = endp;
    vecs[idx].npay     = npay;
    vecs[idx].rmode    = rmode;
    vecs[idx].stall_at = stall_at;
    vecs[idx].exp_len  = exp_len;
    vecs[idx].npre     = npre;
    vecs[idx].pre      = {p2, p1, p0};
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    int   pops, late_pops, cyc;
    logic popped;

    set_vec(0,  4'hd, 7'h00, 4'h0, 0,  0, 0, 3,  3, 8'h2d, 8'h00, 8'h10);
    set_vec(1,  4'h3, 7'h00, 4'h0, 0,  0, 0, 3,  3, 8'hc3, 8'h00, 8'h00);
    set_vec(2,  4'hb, 7'h00, 4'h0, 4,  0, 0, 7,  3, 8'h4b, 8'h00, 8'h01);
    set_vec(3,  4'h2, 7'h00, 4'h0, 0,  0, 0, 1,  1, 8'hd2, 8'h00, 8'h00);
    set_vec(4,  4'h1, 7'h15, 4'h3, 0,  2, 1, 3,  2, 8'he1, 8'h95, 8'h00);
`ifdef USB_SOF_TOKEN_EN
    set_vec(5,  4'h5, 7'h00, 4'h0, 0,  0, 0, 3,  3, 8'ha5, 8'h00, 8'h10);
`else
    set_vec(5,  4'h5, 7'h00, 4'h0, 0,  0, 0, 0,  0, 8'h00, 8'h00, 8'h00);
`endif
    set_vec(6,  4'h4, 7'h00, 4'h0, 0,  0, 0, 0,  0, 8'h00, 8'h00, 8'h00);
    set_vec(7,  4'ha, 7'h00, 4'h0, 0,  0, 0, 1,  1, 8'h5a, 8'h00, 8'h00);
    set_vec(8,  4'he, 7'h00, 4'h0, 0,  0, 0, 1,  1, 8'h1e, 8'h00, 8'h00);
    set_vec(9,  4'h9, 7'h7f, 4'hf, 0,  1, 0, 3,  2, 8'h69, 8'hff, 8'h00);
    set_vec(10, 4'h3, 7'h00, 4'h0, 14, 0, 0, 15, 3, 8'hc3, 8'h00, 8'h01);
    set_vec(11, 4'hb, 7'h00, 4'h0, 3,  2, 2, 6,  3, 8'h4b, 8'h00, 8'h01);

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_rdy", int'(sendPacketRdy), 0);
    check("reset_valid", int'(sieValid), 0);
    check("reset_last", int'(sieLast), 0);
    check("reset_data", int'(sieData), 0);
    check("reset_fifo_ren", int'(fifoREn), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    // WEn while Rdy is still low must be ignored
    @(negedge clk);
    sendPacketPID = 4'h2;
    sendPacketWEn = 1'b1;
    @(posedge clk);
    #1;
    sendPacketWEn = 1'b0;
    @(negedge clk);
    check("rdy_after_reset", int'(sendPacketRdy), 1);
    check("ignored_wen_no_valid", int'(sieValid), 0);
    @(negedge clk);
    check("ignored_wen_no_valid_late", int'(sieValid), 0);

    // Spec vector table
    for (int v = 0; v < 12; v++) begin
      pay_q.delete();
      for (int j = 0; j < vecs[v].npay; j++) pay_q.push_back(8'(j));
      run_packet(vecs[v].pid, vecs[v].addr, vecs[v].endp, 11'h000, vecs[v].rmode,
                 vecs[v].stall_at);
      check($sformatf("tbl%0d_len", v), got_q.size(), vecs[v].exp_len);
      for (int i = 0; i < vecs[v].npre && i < got_q.size(); i++) begin
        check($sformatf("tbl%0d_byte%0d", v, i), int'(got_q[i]), int'(vecs[v].pre[i]));
      end
    end

    // Randomized packets against the reference model
    for (int r = 0; r < 40; r++) begin
      int n;
      pay_q.delete();
      n = $urandom_range(0, 16);
      for (int j = 0; j < n; j++) pay_q.push_back(8'($urandom_range(0, 255)));
      run_packet(4'($urandom_range(0, 15)), 7'($urandom_range(0, 127)),
                 4'($urandom_range(0, 15)), 11'($urandom_range(0, 2047)),
                 $urandom_range(0, 1), 0);
    end

    // Reset during DATA after two payload bytes
    pay_q.delete();
    for (int j = 0; j < 6; j++) pay_q.push_back(8'(8'h10 + j));
    wait_rdy();
    fifo_q = pay_q;
    drive_fifo();
    sendPacketPID = 4'h3;
    sendPacketWEn = 1'b1;
    sieReady      = 1'b1;
    pops = 0; popped = 1'b0; cyc = 0;
    while (pops < 2 && cyc < 20) begin
      @(posedge clk);
      #1;
      sendPacketWEn = 1'b0;
      if (popped && fifo_q.size() > 0) void'(fifo_q.pop_front());
      drive_fifo();
      cyc++;
      @(negedge clk);
      popped = fifoREn;
      if (fifoREn) pops++;
    end
    check("rst_seq_two_pops", pops, 2);
    @(posedge clk);
    #1;
    if (popped && fifo_q.size() > 0) void'(fifo_q.pop_front());
    drive_fifo();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_valid_low", int'(sieValid), 0);
    check("rst_rdy_low", int'(sendPacketRdy), 0);
    late_pops = int'(fifoREn);
    @(negedge clk);
    check("rst_rdy_return", int'(sendPacketRdy), 1);
    check("rst_valid_still_low", int'(sieValid), 0);
    late_pops += int'(fifoREn);
    repeat (3) begin
      @(negedge clk);
      late_pops += int'(fifoREn);
    end
    check("rst_no_late_pops", late_pops, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
